approx_mac_accum: RTL and testbench
===================================

# approx_mac_accum

Streaming accumulator directly downstream of the 8x8 approximate multiplier: it consumes the unsigned 16-bit product stream and sums a programmable number of consecutive products into one saturating dot-product result. The block turns the purely combinational multiplier into a usable MAC datapath for approximate-kernel evaluation, with valid/ready flow control on both sides.

## Interface
- PROD_W, 16, width of the incoming unsigned product (multiplier output R)
- ACC_W, 24, accumulator and result width; must be ≥ PROD_W
- LEN_W, 8, width of the group-length field
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_len  in  LEN_W  products per group; sampled on the first beat of each group; 0 means 2^LEN_W
- in_valid  in  1  product beat valid
- in_ready  out  1  block accepts a beat this cycle
- in_prod  in  PROD_W  unsigned product from the multiplier
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  accumulated sum, saturated
- out_sat  out  1  sticky: saturation occurred within this group

## Operation
- Beat accepted when in_valid && in_ready.
- States: IDLE (no group open), ACCUM (group open), HOLD (result presented).
- IDLE: in_ready=1. On accept: latch len_q=cfg_len, acc=in_prod (zero-extended), cnt=1, sat=0. If len_q==1, go to HOLD, otherwise go to ACCUM.
- ACCUM: in_ready=1. On accept: acc=sat_add(acc,in_prod), cnt=cnt+1. When this beat is the last one (cnt==len_q-1 before the increment, compared modulo 2^LEN_W), go to HOLD.
- len_q==0 gives 2^LEN_W beats (256 at default), because of the natural modulo wrap of cnt.
- HOLD: in_ready=0, out_valid=1. out_acc and out_sat stay stable until out_ready. On out_valid && out_ready, go to IDLE.
- Saturating add: if the true sum ≥ 2^ACC_W, acc=2^ACC_W−1 and sat is set. sat remains set for the rest of the group.
- cfg_len changes mid-group have no effect. Only the value latched on the first beat is used.
- in_prod is treated as unsigned; there is no sign handling.
- in_valid may be deasserted between beats. The group stays open in ACCUM for any number of idle cycles.

## Timing
- Reset values: out_valid=0, out_acc=0, out_sat=0, in_ready=0 during the rst cycle and 1 from the first cycle after rst deasserts. Internal values after reset: state=IDLE, acc=0, cnt=0.
- Latency: the last accepted beat at cycle t gives out_valid=1 at t+1 with the sum including that beat.
- Throughput: with out_ready held high, one group of N beats takes N+1 cycles. in_ready is low only in the single HOLD cycle.
- Back-pressure: out_valid held indefinitely while out_ready=0. No input beat is accepted in HOLD.
- in_ready does not depend combinationally on in_valid or out_ready; it is a function of state only.
- rst asserted mid-group or in HOLD: the partial sum and any pending result are discarded, and the next cycle matches the reset values.

## Structure
- Shared package approx_mult_pkg holds:
  - PROD_W default constant
  - state typedef {IDLE, ACCUM, HOLD}
  - function or localparam for the saturation constant (2^ACC_W−1)
- One sub-module: sat_add. Combinational ACC_W + PROD_W unsigned saturating adder with an overflow flag output.
- The FSM, counter and output registers stay in approx_mac_accum.

## Test plan
- cfg_len=4, beats 100, 200, 300, 400 back-to-back, out_ready=1:
  - out_valid one cycle after the 4th beat, out_acc=1000, out_sat=0
  - in_ready low for exactly that cycle
- cfg_len=1, beat 0xFFFF → out_acc=65535 the next cycle. Then an immediate new group cfg_len=2 with beats 1, 2 → out_acc=3.
- cfg_len=0, 256 beats of 0xFFFF → out_acc=16,776,960 (0xFFFF00), out_sat=0.
- ACC_W=17, cfg_len=3, beats 0xFFFF, 0xFFFF, 5:
  - out_acc=0x1FFFF, out_sat=1
  - the next group of 1 beat with value 7 gives out_sat=0
- out_ready=0 for 10 cycles after result:
  - out_acc stable, in_ready=0, in_valid beats ignored
  - the beat presented in the cycle after the handshake starts a new group
- rst pulsed after 2 of 4 beats (sums 10, 20):
  - the following group cfg_len=2 with beats 5, 6 yields out_acc=11
  - no stale output appears

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier MAC datapath:
// default product width, accumulator FSM state type and the saturation constant.
package approx_mult_pkg;

  localparam int unsigned PROD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // All-ones value of width w (w in 1..64), i.e. 2^w - 1.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return {64{1'b1}} >> (64 - w);
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational unsigned saturating adder: sum_c = min(a + b, 2^ACC_W - 1).
// Ports:
//   a      ACC_W   running accumulator value
//   b      PROD_W  unsigned addend (zero-extended)
//   sum_c  ACC_W   saturated sum
//   ovf_c  1       true sum did not fit in ACC_W bits
module sat_add
  import approx_mult_pkg::*;
#(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned PROD_W = PROD_W_DEF
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [PROD_W-1:0] b,
  output logic [ACC_W-1:0]  sum_c,
  output logic              ovf_c
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] SAT_VAL = ACC_W'(sat_max(ACC_W));

  logic [SUM_W-1:0] wide_c;

  // One extra bit is enough: a single PROD_W addend can overflow ACC_W at most once.
  always_comb begin
    wide_c = {1'b0, a} + SUM_W'(b);
    ovf_c  = wide_c[ACC_W];
    sum_c  = ovf_c ? SAT_VAL : wide_c[ACC_W-1:0];
  end

endmodule

// File: rtl/approx_mac_accum.sv
// Streaming saturating accumulator: sums groups of cfg_len unsigned products
// (0 means 2^LEN_W) and presents each group sum with valid/ready handshake.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   cfg_len            group length, sampled on the first beat of a group
//   in_valid/in_ready  product beat handshake, in_prod the product
//   out_valid/out_ready result handshake
//   out_acc            saturated group sum, out_sat sticky saturation flag
module approx_mac_accum
  import approx_mult_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_sat
);

  acc_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sat_q, sat_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept_c;
  logic               last_c;
  logic [ACC_W-1:0]   add_sum_c;
  logic               add_ovf_c;

  sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .a     (acc_q),
    .b     (in_prod),
    .sum_c (add_sum_c),
    .ovf_c (add_ovf_c)
  );

  // Next-state and datapath; in_ready/out_valid are registered from the next state
  // so they depend on state only.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    sat_d    = sat_q;
    accept_c = in_valid && in_ready_q;
    // Modulo compare makes len_q == 0 close after 2^LEN_W beats.
    last_c   = (cnt_q == (len_q - LEN_W'(1)));

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          len_d   = cfg_len;
          acc_d   = ACC_W'(in_prod);
          cnt_d   = LEN_W'(1);
          sat_d   = 1'b0;
          state_d = (cfg_len == LEN_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_d = add_sum_c;
          sat_d = sat_q | add_ovf_c;
          cnt_d = cnt_q + LEN_W'(1);
          if (last_c) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d != HOLD);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Scoreboard bench: two DUTs (ACC_W=24 and ACC_W=17) share one stimulus stream.
// The driver pushes group-level expected results; a monitor pops and compares.
module tb_approx_mac_accum;

  typedef struct {
    longint acc;
    bit     sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [23:0] out_acc_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [16:0] out_acc_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [15:0] beats[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_mac_accum #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_prod(in_prod), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_sat(out_sat_a)
  );

  approx_mac_accum #(.PROD_W(16), .ACC_W(17), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_prod(in_prod), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_sat(out_sat_b)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: sum with clamp at 2^w-1, sticky saturation flag.
  function automatic exp_t group_result(input int w);
    exp_t   r;
    longint lim;
    lim   = (longint'(1) << w) - 1;
    r.acc = 0;
    r.sat = 1'b0;
    foreach (beats[i]) begin
      r.acc = r.acc + longint'(beats[i]);
      if (r.acc > lim) begin
        r.acc = lim;
        r.sat = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock: inputs already driven; check handshake outputs mid-cycle.
  task automatic step(input bit exp_rdy, input bit exp_vld);
    @(negedge clk);
    chk("in_ready_a", longint'(in_ready_a), longint'(exp_rdy));
    chk("in_ready_b", longint'(in_ready_b), longint'(exp_rdy));
    chk("out_valid_a", longint'(out_valid_a), longint'(exp_vld));
    chk("out_valid_b", longint'(out_valid_b), longint'(exp_vld));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready_a | in_ready_b), 0);
    chk("rst_out_valid", longint'(out_valid_a | out_valid_b), 0);
    chk("rst_out_acc_a", longint'(out_acc_a), 0);
    chk("rst_out_acc_b", longint'(out_acc_b), 0);
    chk("rst_out_sat", longint'(out_sat_a | out_sat_b), 0);
    @(posedge clk);
    #1;
  endtask

  // Feed one group from 'beats'; then hold out_ready low for 'hold' cycles
  // (junk beats offered) and complete the handshake unless rst_in_hold.
  task automatic run_group(input int len_field, input bit gaps, input int hold,
                           input bit rst_in_hold);
    int n;
    n = beats.size();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int ng;
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          in_valid  = 1'b0;
          in_prod   = 16'($urandom);
          cfg_len   = 8'($urandom);
          out_ready = 1'($urandom);
          step(1'b1, 1'b0);
        end
      end
      in_valid  = 1'b1;
      in_prod   = beats[i];
      cfg_len   = (i == 0) ? 8'(len_field) : 8'($urandom);
      out_ready = 1'($urandom);
      if (i == n - 1) begin
        q_a.push_back(group_result(24));
        q_b.push_back(group_result(17));
      end
      step(1'b1, 1'b0);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'($urandom);
      in_prod   = 16'($urandom);
      cfg_len   = 8'($urandom);
      out_ready = 1'b0;
      step(1'b0, 1'b1);
    end
    if (rst_in_hold) begin
      do_reset();
    end else begin
      in_valid  = 1'b1;
      in_prod   = 16'($urandom);
      out_ready = 1'b1;
      step(1'b0, 1'b1);
      in_valid  = 1'b0;
      out_ready = 1'($urandom);
    end
  endtask

  // Monitor: every presented result is compared with the queue head; popped on handshake.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid_a === 1'b1) begin
        if (q_a.size() == 0) begin
          chk("unexpected_result_a", longint'(out_acc_a), -1);
        end else begin
          chk("out_acc_a", longint'(out_acc_a), q_a[0].acc);
          chk("out_sat_a", longint'(out_sat_a), longint'(q_a[0].sat));
          if (out_ready) void'(q_a.pop_front());
        end
      end
      if (out_valid_b === 1'b1) begin
        if (q_b.size() == 0) begin
          chk("unexpected_result_b", longint'(out_acc_b), -1);
        end else begin
          chk("out_acc_b", longint'(out_acc_b), q_b[0].acc);
          chk("out_sat_b", longint'(out_sat_b), longint'(q_b[0].sat));
          if (out_ready) void'(q_b.pop_front());
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    cfg_len   = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Four beats back-to-back: 1000 one cycle after the last beat.
    beats = '{16'd100, 16'd200, 16'd300, 16'd400};
    run_group(4, 1'b0, 0, 1'b0);

    // Single-beat group, then an immediate two-beat group.
    beats = '{16'hFFFF};
    run_group(1, 1'b0, 0, 1'b0);
    beats = '{16'd1, 16'd2};
    run_group(2, 1'b0, 0, 1'b0);

    // cfg_len = 0 -> 256 beats.
    beats.delete();
    for (int i = 0; i < 256; i++) beats.push_back(16'hFFFF);
    run_group(0, 1'b0, 0, 1'b0);

    // Saturation at 17 bits, then a clean single-beat group.
    beats = '{16'hFFFF, 16'hFFFF, 16'd5};
    run_group(3, 1'b0, 0, 1'b0);
    beats = '{16'd7};
    run_group(1, 1'b0, 0, 1'b0);

    // Back-pressure for 10 cycles, next group starts right after the handshake.
    beats = '{16'd11, 16'd22, 16'd33};
    run_group(3, 1'b0, 10, 1'b0);
    beats = '{16'd4, 16'd5};
    run_group(2, 1'b0, 0, 1'b0);

    // Reset after two of four beats, then a fresh group.
    in_valid = 1'b1;
    cfg_len  = 8'd4;
    in_prod  = 16'd10;
    step(1'b1, 1'b0);
    cfg_len  = 8'($urandom);
    in_prod  = 16'd20;
    step(1'b1, 1'b0);
    do_reset();
    beats = '{16'd5, 16'd6};
    run_group(2, 1'b0, 0, 1'b0);

    // Reset while a result is pending.
    beats = '{16'd3, 16'd4};
    run_group(2, 1'b0, 2, 1'b1);
    beats = '{16'd9};
    run_group(1, 1'b0, 0, 1'b0);

    // Random groups: random lengths, values, gaps, back-pressure.
    for (int g = 0; g < 40; g++) begin
      int len;
      len = (g % 13 == 12) ? 0 : int'($urandom_range(1, 20));
      beats.delete();
      for (int i = 0; i < ((len == 0) ? 256 : len); i++) begin
        beats.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end
      run_group(len, 1'b1, int'($urandom_range(0, 4)), 1'b0);
    end

    repeat (3) step(1'b1, 1'b0);
    chk("queue_a_drained", longint'(q_a.size()), 0);
    chk("queue_b_drained", longint'(q_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
